// File: rtl/pc_redirect_ctrl.sv
// Purpose: owns the fetch PC, arbitrates branch/jump redirects and runs a fixed flush window afterwards.
// Latency: new target on pc 1 cycle after an accepted request; first valid fetch FLUSH_CYCLES+1 cycles after it.
// Backpressure: stall freezes the PC in RUN only; redirects override stall and FLUSH ignores stall and requests.
module pc_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        busy,
    output logic [15:0] redirect_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter starts at FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  flush_cnt_q;
    logic [3:0]  flush_cnt_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        flush_q;
    logic        flush_d;
    logic [15:0] redirect_cnt_q;
    logic [15:0] redirect_cnt_d;
    // Low for the first edge after reset release so RESET_PC is held one extra cycle.
    logic        started_q;

    logic        redir_vld;
    logic [31:0] redir_dat;

    // Branch is the older instruction, so it wins; a simultaneous jump is from a squashed path.
    assign redir_vld = br_req | jmp_req;
    assign redir_dat = br_req ? br_target : jmp_target;

    // Next-state, next-PC and redirect counting.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        pc_d           = pc_q;
        flush_d        = flush_q;
        redirect_cnt_d = redirect_cnt_q;
        case (state_q)
            RUN: begin
                if (redir_vld) begin
                    pc_d           = redir_dat & 32'hFFFF_FFFC;
                    state_d        = FLUSH;
                    flush_cnt_d    = FLUSH_INIT;
                    flush_d        = 1'b1;
                    redirect_cnt_d = redirect_cnt_q + 16'd1;
                end else if (!stall && started_q) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH: begin
                // PC holds the target; requests here come from killed instructions.
                if (flush_cnt_q == 4'd0) begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset that overrides everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= RUN;
            flush_cnt_q    <= 4'd0;
            pc_q           <= RESET_PC;
            flush_q        <= 1'b0;
            redirect_cnt_q <= 16'd0;
            started_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            pc_q           <= pc_d;
            flush_q        <= flush_d;
            redirect_cnt_q <= redirect_cnt_d;
            started_q      <= 1'b1;
        end
    end

    assign pc           = pc_q;
    assign flush        = flush_q;
    assign busy         = (state_q == FLUSH);
    assign redirect_cnt = redirect_cnt_q;
    assign fetch_valid  = reset & (state_q == RUN) & ~stall;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose: self-checking bench for pc_redirect_ctrl with FLUSH_CYCLES=2, RESET_PC=0.
// Latency: one vector per clock; fetch_valid checked before the edge, registered outputs after it.
// Backpressure: stall is driven from the vector table like any other input.
module tb_pc_redirect_ctrl;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        br_req;
    logic [31:0] br_target;
    logic        jmp_req;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        busy;
    logic [15:0] redirect_cnt;

    pc_redirect_ctrl #(
        .FLUSH_CYCLES(2),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .br_req      (br_req),
        .br_target   (br_target),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .busy        (busy),
        .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        exp_fv;   // fetch_valid during the cycle these inputs are applied
        logic [31:0] exp_pc;   // registered outputs after the following edge
        logic        exp_fl;
        logic        exp_bz;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt, input logic fv, input logic [31:0] epc,
                                input logic fl, input logic bz, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.exp_fv = fv; v.exp_pc = epc; v.exp_fl = fl; v.exp_bz = bz; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, check the combinational output, push expectations, pop and compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        reset      = v.rst;
        stall      = v.stl;
        br_req     = v.br;
        br_target  = v.bt;
        jmp_req    = v.jmp;
        jmp_target = v.jt;
        #1;
        check("fetch_valid", idx, {31'd0, fetch_valid}, {31'd0, v.exp_fv});
        sb_q.push_back(v);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard vec %0d: got empty queue expected one entry", idx);
        end else begin
            e = sb_q.pop_front();
            check("pc", idx, pc, e.exp_pc);
            check("flush", idx, {31'd0, flush}, {31'd0, e.exp_fl});
            check("busy", idx, {31'd0, busy}, {31'd0, e.exp_bz});
            check("redirect_cnt", idx, {16'd0, redirect_cnt}, {16'd0, e.exp_cnt});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; br_req = 1'b0; br_target = '0; jmp_req = 1'b0; jmp_target = '0;

        //                rst stl br  bt            jmp jt            fv  pc            fl  bz  cnt
        // reset, including requests that must be overridden
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 1, 32'h500,      1, 32'h600,      0, 32'h0,        0, 0, 16'd0));
        // release: first edge holds RESET_PC, then sequential run 4,8,C,10
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 0, 16'd0));
        // branch to 0x103 -> 0x100, two flush cycles, then 0x104
        vecs.push_back(mk(1, 0, 1, 32'h103,      0, 32'h0,        1, 32'h100,      1, 1, 16'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, 1, 16'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 0, 16'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h104,      0, 0, 16'd1));
        // simultaneous requests: branch wins; requests during FLUSH (incl. exit edge) ignored
        vecs.push_back(mk(1, 0, 1, 32'h200,      1, 32'h300,      1, 32'h200,      1, 1, 16'd2));
        vecs.push_back(mk(1, 0, 1, 32'h400,      0, 32'h0,        0, 32'h200,      1, 1, 16'd2));
        vecs.push_back(mk(1, 0, 1, 32'h400,      0, 32'h0,        0, 32'h200,      0, 0, 16'd2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      0, 0, 16'd2));
        // stall holds pc; jump overrides stall; stall through FLUSH does not extend it
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h204,      0, 0, 16'd2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h80,       0, 32'h80,       1, 1, 16'd3));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h80,       1, 1, 16'd3));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h80,       0, 0, 16'd3));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h80,       0, 0, 16'd3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h84,       0, 0, 16'd3));
        // misaligned jump to top of memory, then pc wraps FFFF_FFFC -> 0
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 1, 1, 16'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 1, 1, 16'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 0, 0, 16'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 16'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 0, 16'd4));
        // back-to-back: request at k+2 ignored, at k+3 accepted
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h40,       1, 32'h40,       1, 1, 16'd5));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h40,       1, 1, 16'd5));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h50,       0, 32'h40,       0, 0, 16'd5));
        vecs.push_back(mk(1, 0, 1, 32'h60,       0, 32'h0,        1, 32'h60,       1, 1, 16'd6));
        // reset mid-FLUSH
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 0, 16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // redirect_cnt wrap: preload 0xFFFF, one more redirect must give 0x0000
        force dut.redirect_cnt_q = 16'hFFFF;
        #1;
        release dut.redirect_cnt_q;
        #1;
        apply(mk(1, 0, 1, 32'h700, 0, 32'h0, 1, 32'h700, 1, 1, 16'h0000), 100);
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h700, 1, 1, 16'h0000), 101);
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h700, 0, 0, 16'h0000), 102);
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0, 1, 32'h704, 0, 0, 16'h0000), 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
